rv32_hazard_scoreboard: RTL and testbench

Next-generation pipeline hazard controller for the RV32 core (fetch/decode/execute/mem). It adds a per-register pending-write scoreboard for variable-latency ops (loads, mul/div), an outstanding-op counter, a fence drain FSM and a multi-cycle mispredict flush window. It sits beside the pipeline stages and drives every stage's stall/flush.

---
 rtl/rv32_hazard_pkg.sv | 21 ++
 rtl/rv32_scoreboard.sv | 47 ++++
 rtl/rv32_hazard_scoreboard.sv | 134 +++++++++++++
 tb/tb_rv32_hazard_scoreboard.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_hazard_pkg.sv
// Shared types and sizing helpers for the RV32 hazard controller and its scoreboard.
package rv32_hazard_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic {
    FENCE_IDLE  = 1'b0,
    FENCE_DRAIN = 1'b1
  } fence_state_e;

  // Bits needed to hold 0..max_out, i.e. clog2(max_out+1), never less than 1.
  function automatic int cnt_width(input int max_out);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= max_out) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rv32_scoreboard.sv
// Pending-write bit per register plus an in-flight counter; flags bogus retires.
module rv32_scoreboard
  import rv32_hazard_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_set,
  input  logic [REG_IDX_W-1:0] i_set_idx,
  input  logic                 i_clr,
  input  logic [REG_IDX_W-1:0] i_clr_idx,
  output logic [NUM_REGS-1:0]  o_sb,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_error
);

  logic [NUM_REGS-1:0] r_sb;
  logic [CNT_W-1:0]    r_count;
  logic                r_error;
  logic                w_clr_ok;

  // A retire only takes effect when it matches a pending bit and the counter is nonzero.
  assign w_clr_ok = i_clr && r_sb[i_clr_idx] && (r_count != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sb    <= '0;
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_clr_ok) r_sb[i_clr_idx] <= 1'b0;
      // Set is applied after clear so a same-register issue wins.
      if (i_set) r_sb[i_set_idx] <= 1'b1;
      if (i_set && !w_clr_ok)      r_count <= r_count + CNT_W'(1);
      else if (!i_set && w_clr_ok) r_count <= r_count - CNT_W'(1);
      if (i_clr && !w_clr_ok) r_error <= 1'b1;
    end
  end

  assign o_sb    = r_sb;
  assign o_count = r_count;
  assign o_error = r_error;

endmodule

// File: rtl/rv32_hazard_scoreboard.sv
// Pipeline hazard controller: RAW scoreboard, outstanding limit, fence drain and flush window.
module rv32_hazard_scoreboard
  import rv32_hazard_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int FLUSH_CYCLES    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REG_IDX_W-1:0] decode_rs1_unreg_in,
  input  logic                 decode_rs1_read_unreg_in,
  input  logic [REG_IDX_W-1:0] decode_rs2_unreg_in,
  input  logic                 decode_rs2_read_unreg_in,
  input  logic                 decode_mem_fence_unreg_in,
  input  logic [REG_IDX_W-1:0] decode_rd_in,
  input  logic                 decode_rd_write_in,
  input  logic                 decode_long_lat_in,
  input  logic [REG_IDX_W-1:0] execute_rd_in,
  input  logic                 execute_rd_write_in,
  input  logic                 execute_long_lat_in,
  input  logic                 wb_valid_in,
  input  logic [REG_IDX_W-1:0] wb_rd_in,
  input  logic                 mem_branch_mispredicted_in,
  input  logic                 instr_read_in,
  input  logic                 instr_ready_in,
  input  logic                 data_read_in,
  input  logic                 data_write_in,
  input  logic                 data_ready_in,
  output logic                 fetch_stall_out,
  output logic                 fetch_flush_out,
  output logic                 decode_stall_out,
  output logic                 decode_flush_out,
  output logic                 execute_stall_out,
  output logic                 execute_flush_out,
  output logic                 mem_stall_out,
  output logic                 mem_flush_out,
  output logic [2:0]           outstanding_out,
  output logic                 error_out
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

  fence_state_e        r_fence_state;
  logic [1:0]          r_flush_cnt;
  logic [NUM_REGS-1:0] w_sb;
  logic [CNT_W-1:0]    w_count;
  logic                w_issue;
  logic                w_retire;
  logic                w_dec_ll_wr;
  logic                w_exe_ll_wr;
  logic                w_rs1_hit;
  logic                w_rs2_hit;
  logic                w_raw_hit;
  logic                w_full_hit;
  logic                w_fence_hold;
  logic                w_flush_active;

  assign w_issue  = execute_long_lat_in && execute_rd_write_in && (execute_rd_in != '0) &&
                    !execute_stall_out && !execute_flush_out;
  assign w_retire = wb_valid_in && (wb_rd_in != '0);

  rv32_scoreboard #(
    .NUM_REGS       (NUM_REGS),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_set    (w_issue),
    .i_set_idx(execute_rd_in),
    .i_clr    (w_retire),
    .i_clr_idx(wb_rd_in),
    .o_sb     (w_sb),
    .o_count  (w_count),
    .o_error  (error_out)
  );

  // Producers still in decode/execute are not yet in the scoreboard, so match them directly.
  assign w_dec_ll_wr = decode_rd_write_in && decode_long_lat_in;
  assign w_exe_ll_wr = execute_rd_write_in && execute_long_lat_in;
  assign w_rs1_hit = decode_rs1_read_unreg_in && (decode_rs1_unreg_in != '0) &&
                     (w_sb[decode_rs1_unreg_in] ||
                      (w_dec_ll_wr && (decode_rs1_unreg_in == decode_rd_in)) ||
                      (w_exe_ll_wr && (decode_rs1_unreg_in == execute_rd_in)));
  assign w_rs2_hit = decode_rs2_read_unreg_in && (decode_rs2_unreg_in != '0) &&
                     (w_sb[decode_rs2_unreg_in] ||
                      (w_dec_ll_wr && (decode_rs2_unreg_in == decode_rd_in)) ||
                      (w_exe_ll_wr && (decode_rs2_unreg_in == execute_rd_in)));
  assign w_raw_hit  = w_rs1_hit || w_rs2_hit;
  assign w_full_hit = decode_long_lat_in && (w_count == CNT_W'(MAX_OUTSTANDING)) && !w_retire;

  assign w_fence_hold   = (r_fence_state == FENCE_DRAIN) || decode_mem_fence_unreg_in;
  assign w_flush_active = mem_branch_mispredicted_in || (r_flush_cnt != 2'd0);

  assign mem_stall_out     = (data_read_in || data_write_in) && !data_ready_in;
  assign execute_stall_out = mem_stall_out;
  assign decode_stall_out  = execute_stall_out || w_full_hit;
  assign fetch_stall_out   = decode_stall_out || w_raw_hit || w_fence_hold ||
                             (instr_read_in && !instr_ready_in);
  assign fetch_flush_out   = 1'b0;
  assign decode_flush_out  = fetch_stall_out || w_flush_active;
  assign execute_flush_out = decode_stall_out || w_flush_active;
  assign mem_flush_out     = execute_stall_out;
  assign outstanding_out   = 3'(w_count);

  // Counter holds the remaining cycles of the flush window after the mispredict cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flush_cnt <= 2'd0;
    end else if (mem_branch_mispredicted_in) begin
      r_flush_cnt <= 2'(FLUSH_CYCLES - 1);
    end else if (r_flush_cnt != 2'd0) begin
      r_flush_cnt <= r_flush_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fence_state <= FENCE_IDLE;
    end else begin
      case (r_fence_state)
        FENCE_IDLE:
          if (decode_mem_fence_unreg_in) r_fence_state <= FENCE_DRAIN;
        FENCE_DRAIN:
          if (mem_branch_mispredicted_in ||
              ((w_count == '0) && !mem_stall_out && !w_issue))
            r_fence_state <= FENCE_IDLE;
        default: r_fence_state <= FENCE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_hazard_scoreboard.sv
// Directed bench: combinational vector table under reset, then multi-cycle hazard sequences.
module tb_rv32_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] rs1, rs2, drd, erd, wbrd;
  logic       r1, r2, fence, dwr, dll, ewr, ell, wbv, misp;
  logic       ir, iy, dr, dw, dy;
  logic       fs, ff, ds, df, es, ef, ms, mf, err;
  logic [2:0] outst;
  logic [7:0] flags;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32_hazard_scoreboard #(
    .NUM_REGS(32), .MAX_OUTSTANDING(2), .FLUSH_CYCLES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .decode_rs1_unreg_in(rs1), .decode_rs1_read_unreg_in(r1),
    .decode_rs2_unreg_in(rs2), .decode_rs2_read_unreg_in(r2),
    .decode_mem_fence_unreg_in(fence),
    .decode_rd_in(drd), .decode_rd_write_in(dwr), .decode_long_lat_in(dll),
    .execute_rd_in(erd), .execute_rd_write_in(ewr), .execute_long_lat_in(ell),
    .wb_valid_in(wbv), .wb_rd_in(wbrd),
    .mem_branch_mispredicted_in(misp),
    .instr_read_in(ir), .instr_ready_in(iy),
    .data_read_in(dr), .data_write_in(dw), .data_ready_in(dy),
    .fetch_stall_out(fs), .fetch_flush_out(ff),
    .decode_stall_out(ds), .decode_flush_out(df),
    .execute_stall_out(es), .execute_flush_out(ef),
    .mem_stall_out(ms), .mem_flush_out(mf),
    .outstanding_out(outst), .error_out(err)
  );

  assign flags = {fs, ff, ds, df, es, ef, ms, mf};

  typedef struct {
    string      name;
    logic [4:0] rs1;  logic r1;
    logic [4:0] rs2;  logic r2;
    logic       fence;
    logic [4:0] drd;  logic dwr; logic dll;
    logic [4:0] erd;  logic ewr; logic ell;
    logic       misp, ir, iy, dr, dw, dy;
    logic [7:0] exp;   // {fs,ff,ds,df,es,ef,ms,mf}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic [4:0] a, logic ar, logic [4:0] b, logic br,
                              logic fn, logic [4:0] d, logic dw_, logic dl,
                              logic [4:0] e, logic ew_, logic el, logic mp,
                              logic ir_, logic iy_, logic dr_, logic dwr_, logic dy_,
                              logic [7:0] ex);
    vec_t v;
    v.name = nm; v.rs1 = a; v.r1 = ar; v.rs2 = b; v.r2 = br; v.fence = fn;
    v.drd = d; v.dwr = dw_; v.dll = dl; v.erd = e; v.ewr = ew_; v.ell = el;
    v.misp = mp; v.ir = ir_; v.iy = iy_; v.dr = dr_; v.dw = dwr_; v.dy = dy_;
    v.exp = ex;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    rs1 = 0; r1 = 0; rs2 = 0; r2 = 0; fence = 0; drd = 0; dwr = 0; dll = 0;
    erd = 0; ewr = 0; ell = 0; wbv = 0; wbrd = 0; misp = 0;
    ir = 0; iy = 0; dr = 0; dw = 0; dy = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rd);
    nxt(); idle_in(); erd = rd; ewr = 1; ell = 1;
  endtask

  task automatic retire(input logic [4:0] rd);
    nxt(); idle_in(); wbv = 1; wbrd = rd;
  endtask

  initial begin
    idle_in();
    vecs.push_back(mk("idle",          0,0, 0,0, 0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0, 8'b0000_0000));
    vecs.push_back(mk("fetch_wait",    0,0, 0,0, 0, 0,0,0, 0,0,0, 0, 1,0, 0,0,0, 8'b1001_0000));
    vecs.push_back(mk("fetch_ready",   0,0, 0,0, 0, 0,0,0, 0,0,0, 0, 1,1, 0,0,0, 8'b0000_0000));
    vecs.push_back(mk("data_rd_wait",  0,0, 0,0, 0, 0,0,0, 0,0,0, 0, 0,0, 1,0,0, 8'b1011_1111));
    vecs.push_back(mk("data_wr_ready", 0,0, 0,0, 0, 0,0,0, 0,0,0, 0, 0,0, 0,1,1, 8'b0000_0000));
    vecs.push_back(mk("raw_exe_ll",    5,1, 0,0, 0, 0,0,0, 5,1,1, 0, 0,0, 0,0,0, 8'b1001_0000));
    vecs.push_back(mk("raw_exe_short", 5,1, 0,0, 0, 0,0,0, 5,1,0, 0, 0,0, 0,0,0, 8'b0000_0000));
    vecs.push_back(mk("raw_dec_ll_rs2",0,0, 9,1, 0, 9,1,1, 0,0,0, 0, 0,0, 0,0,0, 8'b1001_0000));
    vecs.push_back(mk("x0_no_stall",   0,1, 0,1, 0, 0,1,1, 0,1,1, 0, 0,0, 0,0,0, 8'b0000_0000));
    vecs.push_back(mk("rs_not_read",   5,0, 5,0, 0, 0,0,0, 5,1,1, 0, 0,0, 0,0,0, 8'b0000_0000));
    vecs.push_back(mk("fence_entry",   0,0, 0,0, 1, 0,0,0, 0,0,0, 0, 0,0, 0,0,0, 8'b1001_0000));
    vecs.push_back(mk("mispredict",    0,0, 0,0, 0, 0,0,0, 0,0,0, 1, 0,0, 0,0,0, 8'b0001_0100));
    vecs.push_back(mk("misp_memstall", 0,0, 0,0, 0, 0,0,0, 0,0,0, 1, 0,0, 1,0,0, 8'b1011_1111));

    // Reset held low: state stays cleared while the table exercises the equations.
    #2;
    chk("reset_outstanding", 32'(outst), 0);
    chk("reset_error", 32'(err), 0);
    chk("reset_flags", 32'(flags), 0);
    foreach (vecs[i]) begin
      rs1 = vecs[i].rs1; r1 = vecs[i].r1; rs2 = vecs[i].rs2; r2 = vecs[i].r2;
      fence = vecs[i].fence; drd = vecs[i].drd; dwr = vecs[i].dwr; dll = vecs[i].dll;
      erd = vecs[i].erd; ewr = vecs[i].ewr; ell = vecs[i].ell; misp = vecs[i].misp;
      ir = vecs[i].ir; iy = vecs[i].iy; dr = vecs[i].dr; dw = vecs[i].dw; dy = vecs[i].dy;
      #1;
      chk(vecs[i].name, 32'(flags), 32'(vecs[i].exp));
    end
    nxt(); idle_in(); reset_n = 1'b1;

    // Load to x5, dependent read stalls until writeback.
    issue(5);
    #1 chk("a_out_before", 32'(outst), 0);
    nxt(); idle_in(); rs1 = 5; r1 = 1;
    #1 chk("a_fs_pending", 32'(fs), 1);
    chk("a_df_pending", 32'(df), 1);
    chk("a_out_1", 32'(outst), 1);
    nxt(); wbv = 1; wbrd = 5;
    #1 chk("a_fs_wb_cycle", 32'(fs), 1);
    nxt(); wbv = 0;
    #1 chk("a_fs_released", 32'(fs), 0);
    chk("a_out_0", 32'(outst), 0);
    chk("a_err", 32'(err), 0);

    // Two loads fill the limit; a third long-latency op in decode stalls.
    issue(1);
    issue(2);
    nxt(); idle_in();
    #1 chk("b_out_2", 32'(outst), 2);
    dll = 1; drd = 3; dwr = 1;
    #1 chk("b_ds_full", 32'(ds), 1);
    chk("b_ef_full", 32'(ef), 1);
    wbv = 1; wbrd = 1;
    #1 chk("b_ds_retire_same", 32'(ds), 0);
    chk("b_ef_retire_same", 32'(ef), 0);
    nxt(); wbv = 0;
    #1 chk("b_out_1", 32'(outst), 1);
    chk("b_ds_below", 32'(ds), 0);
    retire(2);
    nxt(); idle_in();
    #1 chk("b_out_0", 32'(outst), 0);

    // Issue and retire of x7 in the same cycle: set wins, count unchanged.
    issue(7);
    nxt();
    #1 chk("c_out_1", 32'(outst), 1);
    wbv = 1; wbrd = 7;
    nxt(); idle_in(); rs1 = 7; r1 = 1;
    #1 chk("c_out_same", 32'(outst), 1);
    chk("c_err", 32'(err), 0);
    chk("c_sb7_set", 32'(fs), 1);
    retire(7);
    nxt(); idle_in(); rs1 = 7; r1 = 1;
    #1 chk("c_out_0", 32'(outst), 0);
    chk("c_sb7_clear", 32'(fs), 0);
    chk("c_err_after", 32'(err), 0);

    // Single-cycle mispredict holds decode/execute flushed for three cycles.
    nxt(); idle_in(); misp = 1;
    #1 chk("d_df_c0", 32'(df), 1); chk("d_ef_c0", 32'(ef), 1);
    nxt(); misp = 0;
    #1 chk("d_df_c1", 32'(df), 1); chk("d_ef_c1", 32'(ef), 1);
    nxt();
    #1 chk("d_df_c2", 32'(df), 1); chk("d_ef_c2", 32'(ef), 1);
    nxt();
    #1 chk("d_df_c3", 32'(df), 0); chk("d_ef_c3", 32'(ef), 0);

    // Fence drains until the pending op retires and the data bus is idle.
    issue(4);
    nxt(); idle_in(); fence = 1;
    #1 chk("e_fs_fence_in", 32'(fs), 1);
    nxt(); fence = 0;
    #1 chk("e_fs_drain", 32'(fs), 1);
    nxt(); wbv = 1; wbrd = 4; dr = 1;
    nxt(); wbv = 0; wbrd = 0;
    #1 chk("e_out_0", 32'(outst), 0);
    nxt(); dr = 0;
    #1 chk("e_fs_hold_memstall", 32'(fs), 1);
    nxt();
    #1 chk("e_fs_idle", 32'(fs), 0);

    // Mispredict while draining drops the fence hold.
    issue(6);
    nxt(); idle_in(); fence = 1;
    nxt(); fence = 0; misp = 1;
    #1 chk("e2_fs_drain", 32'(fs), 1);
    nxt(); misp = 0;
    #1 chk("e2_fs_after_misp", 32'(fs), 0);
    chk("e2_out_1", 32'(outst), 1);
    nxt(); nxt(); nxt();
    retire(6);
    nxt(); idle_in();
    #1 chk("e2_out_0", 32'(outst), 0);
    chk("e2_err", 32'(err), 0);

    // Retire of a clear register is sticky until reset.
    retire(3);
    nxt(); idle_in();
    #1 chk("f_err_set", 32'(err), 1);
    chk("f_out_0", 32'(outst), 0);
    nxt(); nxt();
    #1 chk("f_err_sticky", 32'(err), 1);
    reset_n = 1'b0;
    #1 chk("f_err_reset", 32'(err), 0);
    nxt(); reset_n = 1'b1;

    // Reset mid-flight discards the pending op, so its later retire is flagged.
    issue(8);
    nxt(); idle_in();
    #1 chk("f_out_pre_reset", 32'(outst), 1);
    reset_n = 1'b0;
    #1 chk("f_out_reset", 32'(outst), 0);
    nxt(); reset_n = 1'b1;
    retire(8);
    nxt(); idle_in();
    #1 chk("f_err_stale_retire", 32'(err), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
